pwm_ramp_ctrl: RTL and testbench

Sequencer that drives the duty_cycle/period configuration inputs of the team's PWM generator. It accepts a new configuration over a valid/ready handshake and applies the new period only at a PWM period boundary. It moves duty_cycle toward the target in programmable steps, one step every N PWM periods, for soft-start and fade. It keeps an internal mirror of the PWM period counter so that every duty/period change lands on a period boundary without glitches.

---
 rtl/pwm_ramp_ctrl.sv | 94 +++++++++
 tb/tb_pwm_ramp_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: handshake-loaded PWM period/duty sequencer with boundary-aligned soft ramping
module pwm_ramp_ctrl #(
    parameter int WIDTH = 16,
    parameter int IVW   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_target,
    input  logic [WIDTH-1:0] cfg_step,
    input  logic [IVW-1:0]   cfg_interval,
    output logic [WIDTH-1:0] duty_cycle,
    output logic [WIDTH-1:0] period,
    output logic             period_tick,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, ARM, RAMP, HOLD} state_t;
    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_cnt, r_duty, r_period, r_sh_period, r_sh_target, r_sh_step;
    logic [IVW-1:0]   r_ivl_cnt, r_sh_ivl;
    logic             r_done;
    logic             w_tick, w_xfer, w_apply, w_jump, w_ivl_last, w_step_now, w_reached;
    logic [WIDTH:0]   w_duty_x, w_tgt_x, w_step_x, w_up, w_dn, w_step_duty;
    assign w_tick      = (r_period != '0) && (r_cnt == r_period - 1'b1);
    assign cfg_ready   = enable && (r_state == IDLE || r_state == HOLD);
    assign w_xfer      = cfg_valid && cfg_ready;
    assign w_apply     = enable && r_state == ARM && (r_period == '0 || w_tick);
    assign w_jump      = r_sh_step == '0 || r_sh_period == '0;
    assign w_ivl_last  = r_ivl_cnt == r_sh_ivl - 1'b1;
    assign w_step_now  = enable && r_state == RAMP && w_tick && w_ivl_last;
    // One extra bit keeps the step arithmetic free of wrap-around
    assign w_duty_x    = {1'b0, r_duty};
    assign w_tgt_x     = {1'b0, r_sh_target};
    assign w_step_x    = {1'b0, r_sh_step};
    assign w_up        = (w_tgt_x - w_duty_x <= w_step_x) ? w_tgt_x : w_duty_x + w_step_x;
    assign w_dn        = (w_duty_x - w_tgt_x <= w_step_x) ? w_tgt_x : w_duty_x - w_step_x;
    assign w_step_duty = (w_duty_x < w_tgt_x) ? w_up : (w_duty_x > w_tgt_x) ? w_dn : w_tgt_x;
    assign w_reached   = w_step_duty == w_tgt_x;
    assign period_tick = w_tick;
    assign duty_cycle  = r_duty;
    assign period      = r_period;
    assign busy        = r_state == ARM || r_state == RAMP;
    assign done        = r_done;
    always_comb begin
        w_state_nxt = !enable ? IDLE :
                      w_xfer ? ARM :
                      w_apply ? (w_jump ? HOLD : RAMP) :
                      (w_step_now && w_reached) ? HOLD : r_state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_duty      <= '0;
            r_period    <= '0;
            r_done      <= 1'b0;
            r_ivl_cnt   <= '0;
            r_sh_period <= '0;
            r_sh_target <= '0;
            r_sh_step   <= '0;
            r_sh_ivl    <= '0;
        end else begin
            r_cnt  <= (r_period == '0 || w_tick) ? '0 : r_cnt + 1'b1;
            r_done <= (w_apply && w_jump) || (w_step_now && w_reached);
            if (!enable) begin
                r_duty      <= '0;
                r_ivl_cnt   <= '0;
                r_sh_period <= '0;
                r_sh_target <= '0;
                r_sh_step   <= '0;
                r_sh_ivl    <= '0;
            end else if (w_xfer) begin
                r_sh_period <= cfg_period;
                r_sh_target <= (cfg_target > cfg_period) ? cfg_period : cfg_target;
                r_sh_step   <= cfg_step;
                r_sh_ivl    <= (cfg_interval == '0) ? IVW'(1) : cfg_interval;
            end else if (w_apply) begin
                r_period  <= r_sh_period;
                r_ivl_cnt <= '0;
                r_duty    <= w_jump ? r_sh_target : (r_duty > r_sh_period) ? r_sh_period : r_duty;
            end else if (r_state == RAMP && w_tick) begin
                r_ivl_cnt <= w_ivl_last ? '0 : r_ivl_cnt + 1'b1;
                if (w_ivl_last) r_duty <= w_step_duty[WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: directed scenarios plus randomized traffic against a behavioural model
module tb_pwm_ramp_ctrl;
    localparam int W  = 16;
    localparam int IV = 8;
    logic          clk = 1'b0, rst_n = 1'b0, enable = 1'b0, cfg_valid = 1'b0;
    logic [W-1:0]  cfg_period = '0, cfg_target = '0, cfg_step = '0;
    logic [IV-1:0] cfg_interval = '0;
    logic          cfg_ready, period_tick, busy, done;
    logic [W-1:0]  duty_cycle, period;
    logic [2*W+3:0] act;
    int checks = 0, errors = 0;
    int m_per, m_cnt, m_duty, m_done, m_mode, m_sp, m_st, m_ss, m_si, m_ic;

    pwm_ramp_ctrl #(.WIDTH(W), .IVW(IV)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_period(cfg_period), .cfg_target(cfg_target), .cfg_step(cfg_step),
        .cfg_interval(cfg_interval), .duty_cycle(duty_cycle), .period(period),
        .period_tick(period_tick), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    assign act = {duty_cycle, period, period_tick, busy, done, cfg_ready};

    // Model modes: 0 = idle/hold, 1 = waiting for a boundary, 2 = ramping
    task automatic model_reset();
        m_per = 0; m_cnt = 0; m_duty = 0; m_done = 0; m_mode = 0;
        m_sp = 0; m_st = 0; m_ss = 0; m_si = 0; m_ic = 0;
    endtask

    function automatic bit m_tick();
        return m_per != 0 && m_cnt == m_per - 1;
    endfunction

    function automatic logic [2*W+3:0] exp_vec();
        return {W'(m_duty), W'(m_per), m_tick(), m_mode != 0, m_done != 0, enable && m_mode == 0};
    endfunction

    task automatic model_edge();
        bit tick;
        tick = m_tick();
        m_cnt = (m_per == 0 || tick) ? 0 : m_cnt + 1;
        m_done = 0;
        if (!enable) begin
            m_duty = 0; m_mode = 0; m_ic = 0;
        end else if (m_mode == 0) begin
            if (cfg_valid) begin
                m_sp = int'(cfg_period);
                m_st = (int'(cfg_target) < m_sp) ? int'(cfg_target) : m_sp;
                m_ss = int'(cfg_step);
                m_si = (cfg_interval == 0) ? 1 : int'(cfg_interval);
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (m_per == 0 || tick) begin
                m_per = m_sp; m_cnt = 0; m_ic = 0;
                if (m_ss == 0 || m_sp == 0) begin
                    m_duty = m_st; m_mode = 0; m_done = 1;
                end else begin
                    if (m_duty > m_sp) m_duty = m_sp;
                    m_mode = 2;
                end
            end
        end else if (tick) begin
            if (m_ic == m_si - 1) begin
                m_ic = 0;
                if (m_duty < m_st)      m_duty = (m_st - m_duty <= m_ss) ? m_st : m_duty + m_ss;
                else if (m_duty > m_st) m_duty = (m_duty - m_st <= m_ss) ? m_st : m_duty - m_ss;
                if (m_duty == m_st) begin m_mode = 0; m_done = 1; end
            end else m_ic++;
        end
    endtask

    task automatic step();
        if (rst_n) model_edge(); else model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int p, input int t, input int s, input int i);
        cfg_valid = 1'b1; cfg_period = W'(p); cfg_target = W'(t); cfg_step = W'(s); cfg_interval = IV'(i);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; cfg_valid = 1'b1; cfg_period = 7; cfg_target = 3;
        repeat (5) step();
        checks++;
        if (duty_cycle !== 0 || period !== 0 || busy !== 0 || done !== 0) begin
            errors++;
            $display("FAIL reset_outputs: duty=%0d period=%0d busy=%b done=%b expected all 0", duty_cycle, period, busy, done);
        end
        cfg_valid = 1'b0; rst_n = 1'b1;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cfg_ready); end
    endtask

    task automatic test_jump();
        int nt = 0, t0 = -1, t1 = -1, nd = 0;
        send(10, 10, 0, 0);
        step();
        checks++;
        if (period !== 10 || duty_cycle !== 10 || done !== 1) begin
            errors++;
            $display("FAIL jump_apply: period=%0d duty=%0d done=%b expected 10/10/1", period, duty_cycle, done);
        end
        for (int k = 1; k <= 20; k++) begin
            step();
            checks++;
            if (act !== exp_vec()) begin errors++; $display("FAIL jump_cycle: got %h expected %h", act, exp_vec()); end
            if (period_tick) begin if (nt == 0) t0 = k; else t1 = k; nt++; end
            if (done) nd++;
        end
        checks++;
        if (nt != 2 || t1 - t0 != 10 || nd != 0) begin
            errors++;
            $display("FAIL jump_ticks: ticks=%0d gap=%0d extra_done=%0d expected 2/10/0", nt, t1 - t0, nd);
        end
    endtask

    task automatic test_ramp_up();
        int seq[$];
        int prev_duty, seen_done = 0, bad_edge = 0, bad_busy = 0;
        logic prev_tick;
        enable = 1'b0;
        step();
        checks++;
        if (duty_cycle !== 0 || period !== 10 || busy !== 0) begin
            errors++;
            $display("FAIL disable_clear: duty=%0d period=%0d busy=%b expected 0/10/0", duty_cycle, period, busy);
        end
        enable = 1'b1;
        send(10, 5, 2, 1);
        prev_duty = int'(duty_cycle); prev_tick = period_tick;
        for (int k = 0; k < 100 && seen_done == 0; k++) begin
            step();
            checks++;
            if (act !== exp_vec()) begin errors++; $display("FAIL ramp_up_cycle: got %h expected %h", act, exp_vec()); end
            if (int'(duty_cycle) != prev_duty) begin seq.push_back(int'(duty_cycle)); if (!prev_tick) bad_edge++; end
            if (done) seen_done = 1; else if (!busy) bad_busy++;
            prev_duty = int'(duty_cycle); prev_tick = period_tick;
        end
        checks++;
        if (seq.size() != 3 || seq[0] != 2 || seq[1] != 4 || seq[2] != 5 || seen_done == 0) begin
            errors++;
            $display("FAIL ramp_up_seq: n=%0d vals=%0d,%0d,%0d done=%0d expected 3 steps 2,4,5 with done", seq.size(), seq[0], seq[1], seq[2], seen_done);
        end
        checks++;
        if (bad_edge != 0 || bad_busy != 0) begin
            errors++;
            $display("FAIL ramp_up_timing: off_tick_changes=%0d busy_drops=%0d expected 0/0", bad_edge, bad_busy);
        end
    endtask

    task automatic test_ramp_down();
        int vals[$], at[$];
        int prev_duty, seen_done = 0, ready_bad = 0;
        send(10, 0, 3, 2);
        prev_duty = int'(duty_cycle);
        for (int k = 0; k < 120 && seen_done == 0; k++) begin
            if (k == 5) begin cfg_valid = 1'b1; cfg_target = 9; cfg_period = 12; cfg_step = 0; end
            if (k == 15) cfg_valid = 1'b0;
            if (cfg_valid && cfg_ready !== 1'b0) ready_bad++;
            step();
            checks++;
            if (act !== exp_vec()) begin errors++; $display("FAIL ramp_down_cycle: got %h expected %h", act, exp_vec()); end
            if (int'(duty_cycle) != prev_duty) begin vals.push_back(int'(duty_cycle)); at.push_back(k); end
            if (done) seen_done = 1;
            prev_duty = int'(duty_cycle);
        end
        checks++;
        if (vals.size() != 2 || vals[0] != 2 || vals[1] != 0 || at[1] - at[0] != 20 || seen_done == 0) begin
            errors++;
            $display("FAIL ramp_down_seq: n=%0d vals=%0d,%0d gap=%0d done=%0d expected 2,0 gap 20 with done", vals.size(), vals[0], vals[1], at[1] - at[0], seen_done);
        end
        checks++;
        if (ready_bad != 0 || period !== 10) begin
            errors++;
            $display("FAIL ramp_down_busy_cfg: ready_high=%0d period=%0d expected 0/10", ready_bad, period);
        end
    endtask

    task automatic test_clamp();
        int nt = 0, got = 0;
        send(10, 20, 0, 0);
        for (int k = 0; k < 30 && got == 0; k++) begin step(); if (done) got = 1; end
        checks++;
        if (got == 0 || duty_cycle !== 10 || period !== 10) begin
            errors++;
            $display("FAIL clamp: done=%0d duty=%0d period=%0d expected 1/10/10", got, duty_cycle, period);
        end
        got = 0;
        send(0, 0, 0, 0);
        for (int k = 0; k < 30 && got == 0; k++) begin step(); if (done) got = 1; end
        checks++;
        if (got == 0 || duty_cycle !== 0 || period !== 0) begin
            errors++;
            $display("FAIL zero_period: done=%0d duty=%0d period=%0d expected 1/0/0", got, duty_cycle, period);
        end
        for (int k = 0; k < 30; k++) begin
            step();
            checks++;
            if (act !== exp_vec()) begin errors++; $display("FAIL zero_period_cycle: got %h expected %h", act, exp_vec()); end
            if (period_tick) nt++;
        end
        checks++;
        if (nt != 0) begin errors++; $display("FAIL zero_period_tick: got %0d ticks expected 0", nt); end
    endtask

    task automatic test_enable_abort();
        int guard = 0;
        send(10, 8, 2, 1);
        while (duty_cycle !== 4 && guard < 100) begin
            step();
            guard++;
            checks++;
            if (act !== exp_vec()) begin errors++; $display("FAIL abort_ramp_cycle: got %h expected %h", act, exp_vec()); end
        end
        checks++;
        if (guard >= 100) begin errors++; $display("FAIL abort_reach4: timeout, duty=%0d expected 4", duty_cycle); end
        enable = 1'b0;
        step();
        checks++;
        if (duty_cycle !== 0 || busy !== 0 || period !== 10 || cfg_ready !== 0 || done !== 0) begin
            errors++;
            $display("FAIL enable_abort: duty=%0d busy=%b period=%0d ready=%b done=%b expected 0/0/10/0/0", duty_cycle, busy, period, cfg_ready, done);
        end
        enable = 1'b1;
        step();
        send(10, 8, 1, 1);
        repeat (25) step();
        rst_n = 1'b0;
        #2;
        checks++;
        if (duty_cycle !== 0 || period !== 0 || busy !== 0 || done !== 0 || period_tick !== 0) begin
            errors++;
            $display("FAIL async_reset: duty=%0d period=%0d busy=%b done=%b tick=%b expected all 0", duty_cycle, period, busy, done, period_tick);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        enable = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            cfg_valid    = ($urandom_range(3, 0) == 0);
            cfg_period   = W'($urandom_range(12, 0));
            cfg_target   = W'($urandom_range(15, 0));
            cfg_step     = W'($urandom_range(4, 0));
            cfg_interval = IV'($urandom_range(3, 0));
            enable       = ($urandom_range(199, 0) != 0);
            step();
            checks++;
            if (act !== exp_vec()) begin errors++; $display("FAIL random_cycle %0d: got %h expected %h", k, act, exp_vec()); end
        end
        cfg_valid = 1'b0;
        enable = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_jump();
        test_ramp_up();
        test_ramp_down();
        test_clamp();
        test_enable_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
